chan_scan_mux: RTL and testbench

CHAN_SCAN_MUX -- requirements
Module: chan_scan_mux

---
 rtl/chan_scan_pkg.sv | 13 +
 rtl/chan_scan_mux_scan_ctr.sv | 44 ++++
 rtl/chan_scan_mux.sv | 103 ++++++++++
 tb/tb_chan_scan_mux.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/chan_scan_pkg.sv
// Shared types and constants for the channel scan multiplexer.
package chan_scan_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_MANUAL = 2'd1,
    ST_SCAN   = 2'd2
  } state_e;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/chan_scan_mux_scan_ctr.sv
// Scan pointer / dwell counter; presents the position for the current scan cycle
// and flags the first channel-0 cycle that follows a wrap.
module scan_ctr #(
  parameter int unsigned N_CH    = 8,
  parameter int unsigned DWELL_W = 8,
  localparam int unsigned SEL_W  = $clog2(N_CH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_run,
  input  logic               i_entry,
  input  logic [DWELL_W-1:0] i_dwell,
  output logic [SEL_W-1:0]   o_ptr_c,
  output logic               o_wrap_c
);

  logic [SEL_W-1:0]   r_ptr;
  logic [DWELL_W-1:0] r_cnt;
  logic [DWELL_W-1:0] w_cnt;

  // Scan entry overrides the stored position with channel 0, count 0.
  always_comb begin
    o_ptr_c  = i_entry ? '0 : r_ptr;
    w_cnt    = i_entry ? '0 : r_cnt;
    o_wrap_c = !i_entry && (o_ptr_c == '0) && (w_cnt == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= '0;
      r_cnt <= '0;
    end else if (!i_run) begin
      r_ptr <= '0;
      r_cnt <= '0;
    end else if (w_cnt >= i_dwell) begin
      r_cnt <= '0;
      r_ptr <= (o_ptr_c == SEL_W'(N_CH - 1)) ? '0 : o_ptr_c + SEL_W'(1);
    end else begin
      r_cnt <= w_cnt + DWELL_W'(1);
      r_ptr <= o_ptr_c;
    end
  end

endmodule

// File: rtl/chan_scan_mux.sv
// Channel multiplexer with manual select and auto-scan modes; all outputs
// are registered one cycle after the inputs they were computed from.
module chan_scan_mux
  import chan_scan_pkg::*;
#(
  parameter int unsigned N_CH    = 8,
  parameter int unsigned W       = 8,
  parameter int unsigned DWELL_W = 8,
  localparam int unsigned SEL_W  = $clog2(N_CH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_CH*W-1:0]   din,
  input  logic [SEL_W-1:0]    sel,
  input  logic                mode,
  input  logic                en,
  input  logic [DWELL_W-1:0]  dwell,
  output logic [W-1:0]        dout,
  output logic [SEL_W-1:0]    ch,
  output logic                valid,
  output logic                wrap,
  output logic                err
);

  state_e           r_state;
  state_e           w_next;
  logic             w_entry;
  logic             w_run;
  logic             w_sel_ok;
  logic [W-1:0]     w_sel_data;
  logic [W-1:0]     w_ptr_data;
  logic [SEL_W-1:0] w_ptr;
  logic             w_wrap;

  always_comb begin
    w_next = ST_IDLE;
    if (en) w_next = (mode == MODE_MANUAL) ? ST_MANUAL : ST_SCAN;
  end

  assign w_entry  = (r_state != ST_SCAN);
  assign w_run    = (w_next == ST_SCAN);
  assign w_sel_ok = (32'(sel) < N_CH);

  // Index decode by compare so out-of-range selects never address din.
  always_comb begin
    w_sel_data = '0;
    w_ptr_data = '0;
    for (int unsigned k = 0; k < N_CH; k++) begin
      if (sel == SEL_W'(k))   w_sel_data = din[k*W +: W];
      if (w_ptr == SEL_W'(k)) w_ptr_data = din[k*W +: W];
    end
  end

  scan_ctr #(
    .N_CH    (N_CH),
    .DWELL_W (DWELL_W)
  ) u_scan_ctr (
    .clk      (clk),
    .rst      (rst),
    .i_run    (w_run),
    .i_entry  (w_entry),
    .i_dwell  (dwell),
    .o_ptr_c  (w_ptr),
    .o_wrap_c (w_wrap)
  );

  // Outputs are driven from the state being entered on this edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      dout    <= '0;
      ch      <= '0;
      valid   <= 1'b0;
      wrap    <= 1'b0;
      err     <= 1'b0;
    end else begin
      r_state <= w_next;
      valid   <= 1'b0;
      wrap    <= 1'b0;
      err     <= 1'b0;
      case (w_next)
        ST_MANUAL: begin
          ch <= sel;
          if (w_sel_ok) begin
            dout  <= w_sel_data;
            valid <= 1'b1;
          end else begin
            dout <= '0;
            err  <= 1'b1;
          end
        end
        ST_SCAN: begin
          dout  <= w_ptr_data;
          ch    <= w_ptr;
          valid <= 1'b1;
          wrap  <= w_wrap;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_chan_scan_mux.sv
// Self-checking bench: manual/scan vectors on 8- and 6-channel instances plus
// randomized traffic against a behavioural model.
module tb_chan_scan_mux;
  localparam int unsigned N8 = 8;
  localparam int unsigned N6 = 6;
  localparam int unsigned W  = 8;
  localparam int unsigned DW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [N8*W-1:0] din8;
  logic [2:0]      sel8;
  logic            mode8, en8;
  logic [DW-1:0]   dwell8;
  logic [W-1:0]    dout8;
  logic [2:0]      ch8;
  logic            valid8, wrap8, err8;

  logic [N6*W-1:0] din6;
  logic [2:0]      sel6;
  logic            mode6, en6;
  logic [DW-1:0]   dwell6;
  logic [W-1:0]    dout6;
  logic [2:0]      ch6;
  logic            valid6, wrap6, err6;

  chan_scan_mux #(.N_CH(N8), .W(W), .DWELL_W(DW)) dut8 (
    .clk(clk), .rst(rst), .din(din8), .sel(sel8), .mode(mode8), .en(en8),
    .dwell(dwell8), .dout(dout8), .ch(ch8), .valid(valid8), .wrap(wrap8), .err(err8));

  chan_scan_mux #(.N_CH(N6), .W(W), .DWELL_W(DW)) dut6 (
    .clk(clk), .rst(rst), .din(din6), .sel(sel6), .mode(mode6), .en(en6),
    .dwell(dwell6), .dout(dout6), .ch(ch6), .valid(valid6), .wrap(wrap6), .err(err6));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(string name, int unsigned act, int unsigned exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk8(string nm, int unsigned d, int unsigned c, int unsigned v,
                      int unsigned wr, int unsigned er);
    chk({nm, ".dout"},  dout8,  d);
    chk({nm, ".ch"},    ch8,    c);
    chk({nm, ".valid"}, valid8, v);
    chk({nm, ".wrap"},  wrap8,  wr);
    chk({nm, ".err"},   err8,   er);
  endtask

  task automatic drive8(logic e, logic m, logic [2:0] s, logic [DW-1:0] d);
    en8 = e; mode8 = m; sel8 = s; dwell8 = d;
    @(posedge clk); #1;
  endtask

  // Behavioural model: scan position expressed as channel index plus cycles spent on it.
  int unsigned m_dout, m_ch, m_valid, m_wrap, m_err;
  int unsigned m_pos, m_held;
  bit          m_scan, m_jw;

  task automatic model_reset();
    m_dout = 0; m_ch = 0; m_valid = 0; m_wrap = 0; m_err = 0;
    m_pos = 0; m_held = 0; m_scan = 0; m_jw = 0;
  endtask

  task automatic model_step();
    m_wrap = 0;
    m_err  = 0;
    if (!en8) begin
      m_valid = 0;
      m_scan  = 0;
    end else if (!mode8) begin
      m_dout  = din8[int'(sel8)*8 +: 8];
      m_ch    = sel8;
      m_valid = 1;
      m_scan  = 0;
    end else begin
      if (!m_scan) begin
        m_pos = 0; m_held = 0; m_jw = 0;
      end
      m_dout  = din8[m_pos*8 +: 8];
      m_ch    = m_pos;
      m_valid = 1;
      m_wrap  = m_jw;
      if (m_held >= dwell8) begin
        m_held = 0;
        m_pos  = (m_pos + 1) % N8;
        m_jw   = (m_pos == 0);
      end else begin
        m_held++;
        m_jw = 0;
      end
      m_scan = 1;
    end
  endtask

  typedef struct {
    logic        en;
    logic        mode;
    logic [2:0]  sel;
    logic [7:0]  dwell;
    logic [7:0]  dout;
    logic [2:0]  ch;
    logic        valid;
    logic        wrap;
    logic        err;
  } vec_t;

  vec_t tbl[10];

  initial begin
    tbl[0] = '{1'b1, 1'b0, 3'd2, 8'd0, 8'h22, 3'd2, 1'b1, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 1'b0, 3'd7, 8'd0, 8'h00, 3'd7, 1'b0, 1'b0, 1'b1};
    tbl[2] = '{1'b1, 1'b0, 3'd5, 8'd0, 8'h25, 3'd5, 1'b1, 1'b0, 1'b0};
    tbl[3] = '{1'b1, 1'b0, 3'd6, 8'd0, 8'h00, 3'd6, 1'b0, 1'b0, 1'b1};
    tbl[4] = '{1'b0, 1'b0, 3'd1, 8'd0, 8'h00, 3'd6, 1'b0, 1'b0, 1'b0};
    tbl[5] = '{1'b1, 1'b0, 3'd0, 8'd0, 8'h20, 3'd0, 1'b1, 1'b0, 1'b0};
    tbl[6] = '{1'b0, 1'b0, 3'd0, 8'd0, 8'h20, 3'd0, 1'b0, 1'b0, 1'b0};
    tbl[7] = '{1'b1, 1'b1, 3'd7, 8'd0, 8'h20, 3'd0, 1'b1, 1'b0, 1'b0};
    tbl[8] = '{1'b1, 1'b1, 3'd7, 8'd0, 8'h21, 3'd1, 1'b1, 1'b0, 1'b0};
    tbl[9] = '{1'b1, 1'b0, 3'd3, 8'd0, 8'h23, 3'd3, 1'b1, 1'b0, 1'b0};

    for (int k = 0; k < int'(N8); k++) din8[k*8 +: 8] = 8'(8'h10 + k);
    for (int k = 0; k < int'(N6); k++) din6[k*8 +: 8] = 8'(8'h20 + k);
    sel8 = '0; mode8 = 1'b0; en8 = 1'b0; dwell8 = '0;
    sel6 = '0; mode6 = 1'b0; en6 = 1'b0; dwell6 = '0;

    #12;
    chk8("reset", 0, 0, 0, 0, 0);
    chk("reset6.valid", valid6, 0);
    @(negedge clk); rst = 1'b0;

    // Six-channel instance: out-of-range selects, idle hold, scan entry.
    for (int i = 0; i < 10; i++) begin
      en6 = tbl[i].en; mode6 = tbl[i].mode; sel6 = tbl[i].sel; dwell6 = tbl[i].dwell;
      @(posedge clk); #1;
      chk($sformatf("tbl%0d.dout", i),  dout6,  tbl[i].dout);
      chk($sformatf("tbl%0d.ch", i),    ch6,    tbl[i].ch);
      chk($sformatf("tbl%0d.valid", i), valid6, tbl[i].valid);
      chk($sformatf("tbl%0d.wrap", i),  wrap6,  tbl[i].wrap);
      chk($sformatf("tbl%0d.err", i),   err6,   tbl[i].err);
    end
    en6 = 1'b0;

    drive8(1, 0, 3'd5, 0);
    chk8("manual5", 8'h15, 5, 1, 0, 0);

    for (int i = 0; i < 9; i++) begin
      drive8(1, 1, 0, 0);
      chk8($sformatf("scan0_%0d", i), 8'h10 + (i % 8), i % 8, 1, (i == 8) ? 1 : 0, 0);
    end

    drive8(1, 0, 3'd1, 0);
    for (int i = 0; i < 25; i++) begin
      drive8(1, 1, 0, 2);
      chk8($sformatf("scan2_%0d", i), 8'h10 + ((i / 3) % 8), (i / 3) % 8, 1,
           (i == 24) ? 1 : 0, 0);
    end

    drive8(1, 0, 3'd2, 0);
    for (int i = 0; i < 5; i++) begin
      drive8(1, 1, 0, 0);
      chk8($sformatf("pre_dis_%0d", i), 8'h10 + i, i, 1, 0, 0);
    end
    for (int i = 0; i < 3; i++) begin
      drive8(0, 1, 0, 0);
      chk8($sformatf("disabled_%0d", i), 8'h14, 4, 0, 0, 0);
    end
    drive8(1, 1, 0, 0);
    chk8("reenable", 8'h10, 0, 1, 0, 0);
    drive8(1, 1, 0, 0);
    drive8(1, 1, 0, 0);
    chk8("pre_arst", 8'h12, 2, 1, 0, 0);

    // Reset raised between edges must clear outputs without a clock.
    #2 rst = 1'b1;
    #1;
    chk8("async_rst", 0, 0, 0, 0, 0);
    @(negedge clk); rst = 1'b0;
    drive8(1, 1, 0, 0);
    chk8("post_rst0", 8'h10, 0, 1, 0, 0);
    drive8(1, 1, 0, 0);
    chk8("post_rst1", 8'h11, 1, 1, 0, 0);

    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    model_reset();
    for (int i = 0; i < 3000; i++) begin
      en8    = ($urandom_range(0, 15) != 0);
      mode8  = ($urandom_range(0, 7) != 0);
      sel8   = 3'($urandom_range(0, 7));
      dwell8 = DW'($urandom_range(0, 3));
      din8   = {$urandom, $urandom};
      model_step();
      @(posedge clk); #1;
      chk8($sformatf("rand%0d", i), m_dout, m_ch, m_valid, m_wrap, m_err);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
